// File: rtl/rf_scan_reader.sv
// rf_scan_reader: autonomous register-file scanner for the board display path.
// Walks RF addresses through one read port at a slow dwell rate and presents
// each captured value with a one-cycle disp_valid pulse. sw_i[13] enables the
// scan, sw_i[12] holds on the current register while still re-reading it.
// Build option: define RF_SCAN_SKIP_ZERO_EN to never show register 0 (the scan
// then starts at, wraps to and parks at address 1).
module rf_scan_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DIV_MAX  = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       sw_i,
  input  logic [31:0]       rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [31:0]       disp_data,
  output logic              disp_valid,
  output logic              scan_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_WAIT    = 2'd3
  } state_t;

`ifdef RF_SCAN_SKIP_ZERO_EN
  // Register 0 is hardwired zero, so the walk parks at and wraps to 1.
  localparam logic [ADDR_W-1:0] PTR_START = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] PTR_START = ADDR_W'(0);
`endif
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]  CNT_TERM = CNT_W'(DIV_MAX - 1);

  // Explicit compare against the last register so non-power-of-2 sizes wrap.
  function automatic logic [ADDR_W-1:0] ptr_advance(input logic [ADDR_W-1:0] p);
    logic [ADDR_W-1:0] n;
    if (p == PTR_LAST) begin
      n = PTR_START;
    end else begin
      n = p + ADDR_W'(1);
    end
    return n;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_disp_addr;
  logic [ADDR_W-1:0] w_disp_addr_nxt;
  logic [31:0]       r_disp_data;
  logic [31:0]       w_disp_data_nxt;
  logic              r_disp_valid;
  logic              w_disp_valid_nxt;
  logic              r_scan_busy;
  logic              w_scan_en;
  logic              w_hold;
  logic              w_unused_sw;

  assign w_scan_en   = sw_i[13];
  assign w_hold      = sw_i[12];
  assign w_unused_sw = ^{sw_i[15:14], sw_i[11:0]};

  assign rd_addr    = r_rd_addr;
  assign disp_addr  = r_disp_addr;
  assign disp_data  = r_disp_data;
  assign disp_valid = r_disp_valid;
  assign scan_busy  = r_scan_busy;

  // Next-state and next-datapath logic; a dropped enable overrides everything.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_cnt_nxt        = r_cnt;
    w_disp_addr_nxt  = r_disp_addr;
    w_disp_data_nxt  = r_disp_data;
    w_disp_valid_nxt = 1'b0;
    if ((r_state != S_IDLE) && !w_scan_en) begin
      w_state_nxt = S_IDLE;
      w_ptr_nxt   = PTR_START;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_ptr_nxt = PTR_START;
          w_cnt_nxt = '0;
          if (w_scan_en) begin
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_ISSUE: begin
          // rd_addr has been stable for a cycle; RF data is settled next.
          w_state_nxt = S_CAPTURE;
        end
        S_CAPTURE: begin
          w_disp_data_nxt  = rd_data;
          w_disp_addr_nxt  = r_ptr;
          w_disp_valid_nxt = 1'b1;
          w_cnt_nxt        = '0;
          w_state_nxt      = S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == CNT_TERM) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_ISSUE;
            // Hold is only looked at here, at the end of the dwell.
            if (w_hold) begin
              w_ptr_nxt = r_ptr;
            end else begin
              w_ptr_nxt = ptr_advance(r_ptr);
            end
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_state_nxt = S_WAIT;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = PTR_START;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers; rd_addr mirrors ptr on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_rd_addr    <= '0;
      r_disp_addr  <= '0;
      r_disp_data  <= 32'd0;
      r_disp_valid <= 1'b0;
      r_scan_busy  <= 1'b0;
    end else begin
      r_ptr        <= w_ptr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rd_addr    <= w_ptr_nxt;
      r_disp_addr  <= w_disp_addr_nxt;
      r_disp_data  <= w_disp_data_nxt;
      r_disp_valid <= w_disp_valid_nxt;
      r_scan_busy  <= (w_state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_rf_scan_reader.sv
// tb_rf_scan_reader: directed bench for rf_scan_reader with DIV_MAX=4.
// A schedule-based model predicts every pulse (time, address, data) and the
// per-cycle busy/rd_addr values; directed steps add literal expectations.
module tb_rf_scan_reader;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DIV  = 4;
`ifdef RF_SCAN_SKIP_ZERO_EN
  localparam int START = 1;
`else
  localparam int START = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   sw  = 16'd0;
  logic [31:0]   rd_data;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] disp_addr;
  logic [31:0]   disp_data;
  logic          disp_valid;
  logic          scan_busy;
  logic [31:0]   rf [NREG];

  always #5 clk = ~clk;

  assign rd_data = rf[rd_addr];

  rf_scan_reader #(
    .NUM_REGS(NREG),
    .ADDR_W  (AW),
    .DIV_MAX (DIV),
    .CNT_W   (25)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_i      (sw),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .scan_busy (scan_busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a pulse is due 2 edges after enabling, then every DIV+2 edges;
  // the address advances (or holds) DIV edges after each pulse.
  int          n_cyc = 0;
  bit          m_on = 1'b0;
  int          m_due = -1;
  int          m_term = -1;
  int          m_addr = START;
  int          m_disp_addr = 0;
  logic [31:0] m_disp_data = 32'd0;
  logic        m_valid = 1'b0;
  logic        m_busy = 1'b0;
  int          m_rd_addr = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_on = 1'b0; m_due = -1; m_term = -1; m_addr = START;
        m_disp_addr = 0; m_disp_data = 32'd0;
        m_valid = 1'b0; m_busy = 1'b0; m_rd_addr = 0;
      end else begin
        n_cyc++;
        m_valid = 1'b0;
        if (!m_on) begin
          if (sw[13]) begin
            m_on = 1'b1; m_due = n_cyc + 2; m_term = -1;
            m_addr = START; m_busy = 1'b1;
          end else begin
            m_busy = 1'b0;
          end
          m_rd_addr = START;
        end else if (!sw[13]) begin
          m_on = 1'b0; m_busy = 1'b0; m_rd_addr = START;
        end else begin
          m_busy = 1'b1;
          if (n_cyc == m_due) begin
            m_valid     = 1'b1;
            m_disp_addr = m_addr;
            m_disp_data = rf[m_addr];
            m_term      = n_cyc + DIV;
            m_due       = n_cyc + DIV + 2;
          end
          if (n_cyc == m_term) begin
            if (!sw[12]) begin
              m_addr = (m_addr == NREG - 1) ? START : m_addr + 1;
            end
            m_rd_addr = m_addr;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("valid", 32'(disp_valid), 32'(m_valid));
        check("busy", 32'(scan_busy), 32'(m_busy));
        check("rd_addr", 32'(rd_addr), 32'(m_rd_addr));
        check("disp_addr", 32'(disp_addr), 32'(m_disp_addr));
        check("disp_data", disp_data, m_disp_data);
      end
    end
  end

  task automatic wait_pulse(output int a, output logic [31:0] d, output int c);
    a = -1; d = 32'd0; c = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (disp_valid) begin
        a = int'(disp_addr); d = disp_data; c = n_cyc;
        return;
      end
    end
    n_total++;
    $display("FAIL pulse_timeout: no disp_valid within 60 cycles at t=%0t", $time);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_disp_addr"}, 32'(disp_addr), 32'd0);
    check({tag, "_disp_data"}, disp_data, 32'd0);
    check({tag, "_valid"}, 32'(disp_valid), 32'd0);
    check({tag, "_busy"}, 32'(scan_busy), 32'd0);
  endtask

  int          a;
  int          c;
  int          prev;
  int          en_edge;
  int          np;
  logic [31:0] d;

  initial begin
    for (int i = 0; i < NREG; i++) rf[i] = 32'(i);
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(scan_busy), 32'd0);
    check("idle_rd_addr", 32'(rd_addr), 32'(START));

    // Enable: first pulse 2 edges after leaving IDLE, then every 6 cycles.
    en_edge = n_cyc + 1;
    sw[13] = 1'b1;
    wait_pulse(a, d, c);
    check("first_addr", 32'(a), 32'(START));
    check("first_data", d, 32'(START));
    check("first_latency", 32'(c - en_edge), 32'd2);
    check("busy_scanning", 32'(scan_busy), 32'd1);
    prev = c;
    wait_pulse(a, d, c);
    check("second_addr", 32'(a), 32'(START + 1));
    check("second_data", d, 32'(START + 1));
    check("period", 32'(c - prev), 32'd6);

    // Walk to the last register and confirm the wrap.
    for (int k = 0; k < 40 && a != 31; k++) wait_pulse(a, d, c);
    prev = c;
    wait_pulse(a, d, c);
    check("wrap_addr", 32'(a), 32'(START));
    check("wrap_data", d, 32'(START));
    check("wrap_period", 32'(c - prev), 32'd6);

    // Hold on register 5 and see a live RF write on the next refresh.
    for (int k = 0; k < 40 && a != 5; k++) wait_pulse(a, d, c);
    @(negedge clk);
    sw[12] = 1'b1;
    rf[5] = 32'hDEADBEEF;
    wait_pulse(a, d, c);
    check("hold_addr1", 32'(a), 32'd5);
    check("hold_data1", d, 32'hDEADBEEF);
    wait_pulse(a, d, c);
    check("hold_addr2", 32'(a), 32'd5);
    @(negedge clk);
    sw[12] = 1'b0;
    wait_pulse(a, d, c);
    check("unhold_addr", 32'(a), 32'd6);
    check("unhold_data", d, 32'd6);

    // Disable during the dwell on register 9.
    for (int k = 0; k < 40 && a != 9; k++) wait_pulse(a, d, c);
    @(negedge clk);
    sw[13] = 1'b0;
    @(posedge clk);
    #1;
    check("dis_busy", 32'(scan_busy), 32'd0);
    check("dis_rd_addr", 32'(rd_addr), 32'(START));
    check("dis_disp_data", disp_data, 32'd9);
    check("dis_disp_addr", 32'(disp_addr), 32'd9);
    np = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (disp_valid) np++;
    end
    check("dis_no_pulse", 32'(np), 32'd0);

    // Re-enable restarts from the first register.
    @(negedge clk);
    sw[13] = 1'b1;
    wait_pulse(a, d, c);
    check("reen_addr", 32'(a), 32'(START));

    // Asynchronous reset mid-dwell, between clock edges.
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_pulse(a, d, c);
    check("post_rst_addr", 32'(a), 32'(START));
    check("post_rst_data", d, 32'(START));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
